// File: rtl/trigger_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trigger_gen_if
// Purpose  : Bundles the request/programming inputs and the waveform/status
//            outputs of trigger_gen into one interface.
// Ports    : advance      - single-cycle request strobe
//            high_cycles  - trigger high time (0 treated as 1)
//            low_cycles   - trigger low guard time (0 treated as 1)
//            clear_ovf    - clears the overflow sticky bit
//            trigger      - level waveform output
//            busy         - waveform in progress
//            pending      - queued requests not yet started
//            overflow     - sticky: a request was dropped
//            done         - one-cycle pulse after each low phase
//                           (only when TRIGGER_GEN_DONE_EN is defined)
// Modports : master drives requests and programming, slave is the generator.
// Revision : 1.0 - initial release
// ============================================================================
interface trigger_gen_if #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
);
  logic              advance;
  logic [CNT_W-1:0]  high_cycles;
  logic [CNT_W-1:0]  low_cycles;
  logic              clear_ovf;
  logic              trigger;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;
`ifdef TRIGGER_GEN_DONE_EN
  logic              done;

  modport master (
    output advance, high_cycles, low_cycles, clear_ovf,
    input  trigger, busy, pending, overflow, done
  );
  modport slave (
    input  advance, high_cycles, low_cycles, clear_ovf,
    output trigger, busy, pending, overflow, done
  );
`else
  modport master (
    output advance, high_cycles, low_cycles, clear_ovf,
    input  trigger, busy, pending, overflow
  );
  modport slave (
    input  advance, high_cycles, low_cycles, clear_ovf,
    output trigger, busy, pending, overflow
  );
`endif
endinterface
`default_nettype wire

// File: rtl/trigger_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trigger_gen
// Purpose  : Turns single-cycle advance strobes into clean level trigger
//            waveforms with programmable high and low (guard) times. Requests
//            that arrive while a waveform is running are counted and replayed
//            back-to-back, always separated by at least one low cycle.
// Ports    : clock    - system clock, posedge
//            reset_n  - synchronous reset, active-low
//            bus      - trigger_gen_if.slave (advance, high_cycles,
//                       low_cycles, clear_ovf in; trigger, busy, pending,
//                       overflow [, done] out)
// Options  : TRIGGER_GEN_DONE_EN adds the done completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_gen #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  trigger_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trigger_q;
  logic              busy_q;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;

  logic              w_req_avail;
  logic              w_cnt_zero;
  logic [CNT_W-1:0]  w_high_load;
  logic [CNT_W-1:0]  w_low_load;
  logic              w_start;
  logic              w_low_end;
  logic              w_drop;

  assign w_req_avail = bus.advance | (pending_q != '0);
  assign w_cnt_zero  = (cnt_q == '0);
  // A programmed time of 0 behaves as 1, so both map to a load of 0.
  assign w_high_load = (bus.high_cycles == '0) ? '0 : bus.high_cycles - CNT_W'(1);
  assign w_low_load  = (bus.low_cycles  == '0) ? '0 : bus.low_cycles  - CNT_W'(1);

  // Phase sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_start   = 1'b0;
    w_low_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_req_avail) w_start = 1'b1;
      end
      ST_HIGH: begin
        if (w_cnt_zero) begin
          state_d = ST_LOW;
          cnt_d   = w_low_load;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (w_cnt_zero) begin
          w_low_end = 1'b1;
          if (w_req_avail) w_start = 1'b1;
          else             state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_start) begin
      state_d = ST_HIGH;
      cnt_d   = w_high_load;
    end
  end

  // Request bookkeeping. A start consumes a queued request first; a
  // same-cycle strobe then refills that slot, so pending is unchanged.
  // With nothing queued the starting strobe is consumed directly.
  always_comb begin
    pending_d = pending_q;
    w_drop    = 1'b0;
    if (w_start) begin
      if (pending_q != '0 && !bus.advance) pending_d = pending_q - PEND_W'(1);
    end else if (bus.advance) begin
      if (pending_q == PEND_MAX) w_drop    = 1'b1;
      else                       pending_d = pending_q + PEND_W'(1);
    end
    // Clearing wins over a drop in the same cycle.
    overflow_d = bus.clear_ovf ? 1'b0 : (overflow_q | w_drop);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      trigger_q  <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trigger_q  <= (state_d == ST_HIGH);
      busy_q     <= (state_d != ST_IDLE);
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.trigger  = trigger_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

`ifdef TRIGGER_GEN_DONE_EN
  logic done_q;

  // One pulse per waveform: the cycle after its low phase finishes.
  always_ff @(posedge clock) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= w_low_end;
  end

  assign bus.done = done_q;
`endif

endmodule
`default_nettype wire

// File: doc/trigger_gen.md
Name: trigger_gen

Overview:
- Inverse of the edge-to-pulse detector used across the design: converts single-cycle `advance` request pulses into clean level `trigger` waveforms.
- Each waveform has a programmable high time and low (guard) time, so a downstream rising-edge detector samples every request reliably, including one running in a slower or unrelated clock domain.
- Requests arriving while a waveform is in progress are counted and replayed back-to-back.
- Sits between sequencing logic that emits advance strobes and peripherals or other clock domains that consume a trigger level.

Parameters:
- CNT_W, 8, width of `high_cycles`/`low_cycles` and of the internal phase counter.
- PEND_W, 4, width of the pending-request counter; saturates at 2^PEND_W-1.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset_n  input  1  synchronous reset, active-low.
- advance  input  1  single-cycle request strobe; each high cycle is one request.
- high_cycles  input  CNT_W  trigger high time in clocks; 0 treated as 1.
- low_cycles  input  CNT_W  trigger low guard time in clocks; 0 treated as 1.
- clear_ovf  input  1  clears `overflow` sticky bit.
- trigger  output  1  registered level waveform.
- busy  output  1  high while state is not IDLE.
- pending  output  PEND_W  queued requests not yet started.
- overflow  output  1  sticky: a request was dropped because `pending` was saturated.

Behaviour:
- Reset and clock: one clock, `clock`. Reset is synchronous, active-low on `reset_n`, sampled on posedge.
- Reset values (one cycle after a sampled reset_n=0): trigger=0, busy=0, pending=0, overflow=0, state=IDLE, phase counter=0.
- Reset mid-waveform aborts immediately. Trigger is 0 on the next cycle. No queued request survives.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - Stays in IDLE while no request is available.
  - A request is available when advance=1 or pending>0.
  - On a request: go to HIGH; load counter with max(high_cycles,1)-1; trigger<=1.
- Start latency: advance sampled high at edge k gives trigger=1 from edge k+1. Fixed 1-cycle latency.
- HIGH:
  - Counter decrements each cycle.
  - On reaching 0: go to LOW; load counter with max(low_cycles,1)-1; trigger<=0.
  - Trigger is high for exactly max(high_cycles,1) cycles.
- LOW:
  - Counter decrements each cycle.
  - On reaching 0, if a request is available: go directly to HIGH, with the same load and trigger rules as IDLE.
  - On reaching 0 with no request available: go to IDLE.
  - Low time is exactly max(low_cycles,1) cycles before the next rise.
- `high_cycles` is sampled only on entry to HIGH and `low_cycles` only on entry to LOW. Changes mid-phase take effect at the next phase entry.
- Request consumption: a new waveform started from IDLE or LOW consumes one request.
  - Queued requests are consumed first.
  - If pending>0, pending decrements, and any same-cycle advance increments it, so the net change is 0.
  - If pending=0 and advance=1, the strobe is consumed directly and pending stays 0.
- advance=1 while no waveform start occurs (in HIGH, or in LOW with counter≠0): pending increments.
- Saturation: if pending = 2^PEND_W-1 and an advance must be queued, the request is dropped, pending holds, and overflow<=1.
  - A same-cycle dequeue frees a slot, so no drop occurs in that case.
- overflow stays set until clear_ovf=1.
  - clear_ovf has priority over a simultaneous new overflow, i.e. overflow=0 afterwards.
- busy equals (state≠IDLE), registered with the state.
- Waveforms never merge. Back-to-back requests always produce distinct rising edges separated by ≥1 low cycle.

Optional Feature:
- Macro: TRIGGER_GEN_DONE_EN.
- When defined:
  - Adds output `done` (1 bit, reset 0).
  - `done` pulses high for exactly one cycle on the cycle after each LOW phase completes, whether the next state is IDLE or HIGH.
  - One pulse per waveform; usable as a completion acknowledge.
- When undefined: no `done` port and no extra logic. All other behaviour is identical.

Test Plan:
- Reset, then a single strobe: hold reset_n=0 for 3 cycles with advance=1; all outputs 0. Release, then advance pulse at edge 10 with high=3, low=2. Required: trigger=1 on cycles 11-13, 0 on 14-15; busy=1 on 11-15; busy=0 from 16; pending=0 throughout.
- Queueing, back-to-back: high=2, low=1; advance pulses at edges 0, 1, 2. Required: pending reaches 2. Three distinct highs: cycles 1-2, 4-5, 7-8, each separated by one low cycle. Pending returns to 0; busy falls after cycle 9.
- Zero programming: high_cycles=0, low_cycles=0; two strobes 1 cycle apart. Required: each high and each low lasts exactly 1 cycle; the second rise is 2 cycles after the first.
- Overflow and clear: PEND_W=4, high=50. Issue 17 strobes during the first high. Required: pending saturates at 15 and overflow=1. clear_ovf pulse clears it. Exactly 16 waveforms are emitted in total.
- Reset mid-operation: assert reset_n=0 during the 2nd cycle of a high=5 phase with pending=3. Required: next cycle trigger=0, pending=0, busy=0, and no further waveforms.
- With TRIGGER_GEN_DONE_EN: run the back-to-back case. Required: exactly 3 single-cycle done pulses, each the cycle after a low phase ends.
